// File: rtl/uart_apb_arbiter.sv
// rtl/uart_apb_arbiter.sv - round-robin two-requester APB master in front of uart_apb
// Requests are accepted only in IDLE; each transfer ends in one rsp_valid pulse (data or timeout error).
module uart_apb_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam int              CNT_W    = $clog2(TIMEOUT) + 1;
  localparam bit              TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic grant;
  logic any_req;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    any_req = |req_valid;
    if (req_valid == 2'b10) begin
      grant = 1'b1;
    end else if (req_valid == 2'b01) begin
      grant = 1'b0;
    end else begin
      grant = ~last_grant_q;
    end
  end

  always_comb begin
    req_ready = 2'b00;
    if (resetn && (state_q == ST_IDLE) && any_req) begin
      req_ready = grant ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    rsp_valid_d  = 2'b00;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          paddr_d      = grant ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
          pwdata_d     = grant ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
          pwrite_d     = grant ? req_write[1] : req_write[0];
          last_grant_d = grant;
          psel_d       = 1'b1;
          state_d      = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        // last_grant_q still names the owner of the transfer in flight.
        if (pready) begin
          rsp_valid_d = last_grant_q ? 2'b10 : 2'b01;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = 1'b0;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = ST_IDLE;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          rsp_valid_d = last_grant_q ? 2'b10 : 2'b01;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = ST_IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_uart_apb_arbiter.sv
// tb/tb_uart_apb_arbiter.sv - randomized transaction-level bench for uart_apb_arbiter
// Expected grants, bus values and response timing come from the arbitration rules and cycle arithmetic.
module tb_uart_apb_arbiter;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic                clk = 1'b0;
  logic                resetn = 1'b0;
  logic [1:0]          req_valid = 2'b00;
  logic [1:0]          req_write = 2'b00;
  logic [2*ADDR_W-1:0] req_addr = '0;
  logic [2*DATA_W-1:0] req_wdata = '0;
  logic [1:0]          req_ready;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;
  logic                psel, penable, pwrite;
  logic [ADDR_W-1:0]   paddr;
  logic [DATA_W-1:0]   pwdata;
  logic [DATA_W-1:0]   prdata = '0;
  logic                pready = 1'b0;

  always #5 clk = ~clk;

  uart_apb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model state: who won last, the response owed next idle cycle, and the held response fields.
  bit          m_last = 1'b1;
  bit          pend = 1'b0;
  logic [1:0]  pend_valid = 2'b00;
  logic [31:0] pend_rdata = '0;
  logic        pend_err = 1'b0;
  logic [31:0] held_rdata = '0;
  logic        held_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit pick(input logic [1:0] v, input bit last);
    if (v == 2'b10) return 1'b1;
    if (v == 2'b01) return 1'b0;
    return ~last;
  endfunction

  task automatic check_resp();
    if (pend) begin
      check("rsp_valid", rsp_valid, pend_valid);
      check("rsp_rdata", rsp_rdata, pend_rdata);
      check("rsp_err", rsp_err, pend_err);
      held_rdata = pend_rdata;
      held_err   = pend_err;
      pend       = 1'b0;
    end else begin
      check("rsp_quiet", rsp_valid, 2'b00);
      check("rsp_rdata_hold", rsp_rdata, held_rdata);
      check("rsp_err_hold", rsp_err, held_err);
    end
  endtask

  // Entered at posedge+1 of an IDLE cycle; returns at posedge+1 of the response (IDLE) cycle.
  task automatic xfer(input logic [1:0] pat, input logic [7:0] a0, input logic [7:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] wr,
                      input int w, input bit hold, input int rst_k, input logic [31:0] rd);
    bit          g;
    bit          ew;
    bit          abort;
    int          n_acc;
    logic [7:0]  ea;
    logic [31:0] ed;
    req_valid = pat;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    req_write = wr;
    pready    = 1'b0;
    @(negedge clk);
    g = pick(pat, m_last);
    check_resp();
    check("idle_psel", psel, 1'b0);
    check("idle_penable", penable, 1'b0);
    check("grant_ready", req_ready, g ? 2'b10 : 2'b01);
    ea = g ? a1 : a0;
    ed = g ? d1 : d0;
    ew = wr[g];
    @(posedge clk);
    m_last = g;
    #1;
    req_addr  = 16'($urandom);
    req_wdata = {$urandom, $urandom};
    req_write = 2'($urandom);
    if (!hold) req_valid = 2'($urandom);
    @(negedge clk);
    check("setup_psel", psel, 1'b1);
    check("setup_penable", penable, 1'b0);
    check("setup_paddr", paddr, ea);
    check("setup_pwdata", pwdata, ed);
    check("setup_pwrite", pwrite, ew);
    check("setup_ready", req_ready, 2'b00);
    check("setup_rsp", rsp_valid, 2'b00);
    abort = (TIMEOUT != 0) && (w >= TIMEOUT);
    n_acc = abort ? TIMEOUT : w + 1;
    for (int k = 0; k < n_acc; k++) begin
      @(posedge clk);
      #1;
      pready = !abort && (k == w);
      prdata = pready ? rd : $urandom;
      if (k == rst_k) begin
        pready    = 1'b0;
        req_valid = 2'b11;
        #2 resetn = 1'b0;
        #1;
        check("rst_psel", psel, 1'b0);
        check("rst_penable", penable, 1'b0);
        check("rst_rsp", rsp_valid, 2'b00);
        check("rst_ready", req_ready, 2'b00);
        check("rst_paddr", paddr, 8'h00);
        req_valid  = 2'b00;
        m_last     = 1'b1;
        pend       = 1'b0;
        held_rdata = '0;
        held_err   = 1'b0;
        @(negedge clk);
        check("rst_rsp_low", rsp_valid, 2'b00);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        return;
      end
      if (!hold) req_valid = 2'($urandom);
      req_addr  = 16'($urandom);
      req_wdata = {$urandom, $urandom};
      @(negedge clk);
      check("acc_psel", psel, 1'b1);
      check("acc_penable", penable, 1'b1);
      check("acc_paddr", paddr, ea);
      check("acc_pwdata", pwdata, ed);
      check("acc_pwrite", pwrite, ew);
      check("acc_ready", req_ready, 2'b00);
      check("acc_rsp", rsp_valid, 2'b00);
    end
    @(posedge clk);
    #1;
    pready     = 1'b0;
    prdata     = $urandom;
    pend       = 1'b1;
    pend_valid = g ? 2'b10 : 2'b01;
    pend_rdata = (abort || ew) ? 32'h0 : rd;
    pend_err   = abort;
  endtask

  task automatic idle_cycle();
    req_valid = 2'b00;
    @(negedge clk);
    check_resp();
    check("idle_ready", req_ready, 2'b00);
    check("idle_psel", psel, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    req_valid = 2'b11;
    #2;
    check("reset_ready", req_ready, 2'b00);
    check("reset_psel", psel, 1'b0);
    check("reset_penable", penable, 1'b0);
    check("reset_pwrite", pwrite, 1'b0);
    check("reset_paddr", paddr, 8'h00);
    check("reset_pwdata", pwdata, 32'h0);
    check("reset_rsp_valid", rsp_valid, 2'b00);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err", rsp_err, 1'b0);
    req_valid = 2'b00;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Both valid out of reset: grants must run 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      check("fair_order_model", {31'd0, pick(2'b11, m_last)}, (i % 2));
      xfer(2'b11, 8'(8'h10 + i), 8'(8'h20 + i), $urandom, $urandom, 2'($urandom), 0, 1'b1, -1, $urandom);
    end
    xfer(2'b01, 8'h04, 8'h77, 32'hA5A5_0001, 32'h1234_5678, 2'b01, 0, 1'b0, -1, 32'hDEAD_BEEF);
    xfer(2'b10, 8'h33, 8'h08, 32'h0, 32'h0, 2'b00, 3, 1'b0, -1, 32'h0000_005A);
    xfer(2'b01, 8'h0C, 8'h00, 32'h0, 32'h0, 2'b00, 40, 1'b0, -1, 32'h1111_1111);
    xfer(2'b01, 8'h0C, 8'h00, 32'h0, 32'h0, 2'b00, 0, 1'b0, -1, 32'h2222_2222);
    xfer(2'b10, 8'h00, 8'h14, 32'h0, 32'h0, 2'b00, TIMEOUT - 1, 1'b0, -1, 32'h3333_3333);
    xfer(2'b01, 8'h18, 8'h00, 32'h0, 32'h0, 2'b00, 5, 1'b0, 2, 32'h4444_4444);
    xfer(2'b10, 8'h00, 8'h1C, 32'h0, 32'h5555_5555, 2'b10, 1, 1'b0, -1, 32'h6666_6666);

    for (int i = 0; i < 200; i++) begin
      int w;
      int rk;
      w  = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 4) : $urandom_range(0, 4);
      rk = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 1) : -1;
      if (rk >= 0 && w < rk) rk = -1;
      xfer(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom), $urandom, $urandom,
           2'($urandom), w, 1'($urandom), rk, $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
